// File: rtl/hbm_channel_bridge_pkg.sv
// Shared definitions for the HBM pseudo-channel bridge.
// Default geometry, queue sizing and the per-cycle event bundle.
package hbm_channel_bridge_pkg;

  localparam int HBM_AWIDTH_DEF      = 32;
  localparam int HBM_DWIDTH_DEF      = 512;
  localparam int GROUP_CORE_NUM_DEF  = 4;
  localparam int HBM_RQST_DEPTH_DEF  = 64;
  localparam int HBM_RQST_PF_DEF     = 8;
  localparam int HBM_RESP_DEPTH_DEF  = 64;
  localparam int HBM_MAX_OUTSTANDING_DEF = 32;

  // Width of a counter able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Decisions taken in one cycle by the bridge control logic.
  typedef struct packed {
    logic issue;
    logic retire;
    logic resp_wr;
    logic resp_drop;
    logic rqst_drop;
  } bridge_ev_t;

endpackage

// File: rtl/hbm_channel_bridge_fifo.sv
// sync_fifo_fwft: show-ahead synchronous FIFO with a registered head.
// Ports: wr_en/din write side, rd_en/dout/empty read side, full, prog_full.
module sync_fifo_fwft
  import hbm_channel_bridge_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int PF_MARGIN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             prog_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH) + 1;
  localparam logic [CW-1:0] PF_THR = CW'(DEPTH - PF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [AW:0]      mcount;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;
  logic             mem_empty;
  logic             wr_ok;
  logic             pop;
  logic             load;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    occ_next;

  assign mem_empty = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_ok     = wr_en && !full;
  assign pop       = rd_en && out_vld;
  // Head register refills whenever it is free or being drained.
  assign load      = !mem_empty && (!out_vld || pop);

  assign mcount   = wptr - rptr;
  assign occ      = CW'(mcount) + CW'(out_vld);
  assign occ_next = occ + CW'(wr_ok) - CW'(pop);

  assign dout  = out_q;
  assign empty = !out_vld;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      out_q     <= '0;
      out_vld   <= 1'b0;
      prog_full <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (load) begin
        rptr  <= rptr + 1'b1;
        out_q <= mem[rptr[AW-1:0]];
      end
      out_vld   <= load || (out_vld && !pop);
      prog_full <= (occ_next >= PF_THR);
    end
  end

endmodule

// File: rtl/hbm_channel_bridge.sv
// Bridge between the edge-fetch front end and one HBM pseudo-channel:
// credit-limited request issue, per-core response fan-out, sticky errors.
module hbm_channel_bridge
  import hbm_channel_bridge_pkg::*;
#(
  parameter int HBM_AWIDTH      = HBM_AWIDTH_DEF,
  parameter int HBM_DWIDTH      = HBM_DWIDTH_DEF,
  parameter int GROUP_CORE_NUM  = GROUP_CORE_NUM_DEF,
  parameter int PSEUDO_ID       = 0,
  parameter int RQST_DEPTH      = HBM_RQST_DEPTH_DEF,
  parameter int RQST_PF_MARGIN  = HBM_RQST_PF_DEF,
  parameter int RESP_DEPTH      = HBM_RESP_DEPTH_DEF,
  parameter int MAX_OUTSTANDING = HBM_MAX_OUTSTANDING_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HBM_AWIDTH-1:0]         front_rd_hbm_edge_addr,
  input  logic                          front_rd_hbm_edge_valid,
  output logic                          stage_full,
  input  logic                          hbm_controller_full,
  output logic [HBM_AWIDTH-1:0]         rd_hbm_edge_addr,
  output logic                          rd_hbm_edge_valid,
  input  logic [HBM_DWIDTH-1:0]         hbm_controller_edge,
  input  logic                          hbm_controller_valid,
  output logic [HBM_DWIDTH-1:0]         active_v_edge,
  output logic [GROUP_CORE_NUM-1:0]     active_v_edge_valid,
  input  logic [GROUP_CORE_NUM-1:0]     active_v_edge_ready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                          err_rqst_overflow,
  output logic                          err_unexpected_resp
);

  localparam int OW = cnt_width(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING > RESP_DEPTH) begin : g_cfg_err
    $error("hbm_channel_bridge: MAX_OUTSTANDING > RESP_DEPTH");
  end

  logic [HBM_AWIDTH-1:0]     rq_dout;
  logic                      rq_empty;
  logic                      rq_full;
  logic [HBM_DWIDTH-1:0]     rs_dout;
  logic                      rs_empty;
  logic                      rs_full;
  logic                      rs_pf;
  logic [GROUP_CORE_NUM-1:0] delivered;
  logic [GROUP_CORE_NUM-1:0] accept;
  logic [GROUP_CORE_NUM-1:0] done_mask;
  logic                      credit_ok;
  logic                      idle_out;
  bridge_ev_t                ev;

  // Response FIFO space is guaranteed by the credit limit.
  logic unused_rs_flags;
  assign unused_rs_flags = ^{rs_full, rs_pf, PSEUDO_ID[0]};

  sync_fifo_fwft #(
    .WIDTH     (HBM_AWIDTH),
    .DEPTH     (RQST_DEPTH),
    .PF_MARGIN (RQST_PF_MARGIN)
  ) u_rqst_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (front_rd_hbm_edge_valid),
    .din       (front_rd_hbm_edge_addr),
    .rd_en     (ev.issue),
    .dout      (rq_dout),
    .empty     (rq_empty),
    .full      (rq_full),
    .prog_full (stage_full)
  );

  sync_fifo_fwft #(
    .WIDTH     (HBM_DWIDTH),
    .DEPTH     (RESP_DEPTH),
    .PF_MARGIN (0)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (ev.resp_wr),
    .din       (hbm_controller_edge),
    .rd_en     (ev.retire),
    .dout      (rs_dout),
    .empty     (rs_empty),
    .full      (rs_full),
    .prog_full (rs_pf)
  );

  assign credit_ok = (outstanding < OW'(MAX_OUTSTANDING));
  assign idle_out  = (outstanding == '0);

  assign active_v_edge       = rs_dout;
  assign active_v_edge_valid = rs_empty ? '0 : ~delivered;

  always_comb begin
    ev           = '0;
    accept       = active_v_edge_valid & active_v_edge_ready;
    done_mask    = delivered | accept;
    ev.issue     = !rq_empty && !hbm_controller_full && credit_ok;
    ev.rqst_drop = front_rd_hbm_edge_valid && rq_full;
    ev.resp_wr   = hbm_controller_valid && !idle_out;
    ev.resp_drop = hbm_controller_valid && idle_out;
    // A word retires once every core has taken it, this cycle or earlier.
    ev.retire    = !rs_empty && (&done_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hbm_edge_addr    <= '0;
      rd_hbm_edge_valid   <= 1'b0;
      delivered           <= '0;
      outstanding         <= '0;
      err_rqst_overflow   <= 1'b0;
      err_unexpected_resp <= 1'b0;
    end else begin
      rd_hbm_edge_valid <= ev.issue;
      if (ev.issue) begin
        rd_hbm_edge_addr <= rq_dout;
      end
      delivered <= ev.retire ? '0 : done_mask;
      unique case (1'b1)
        (ev.issue && !ev.retire): outstanding <= outstanding + OW'(1);
        (ev.retire && !ev.issue): outstanding <= outstanding - OW'(1);
        default:                  outstanding <= outstanding;
      endcase
      if (ev.rqst_drop) begin
        err_rqst_overflow <= 1'b1;
      end
      if (ev.resp_drop) begin
        err_unexpected_resp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hbm_channel_bridge.sv
// Self-checking bench for hbm_channel_bridge.
// Scoreboard of requests, issued addresses and per-core delivered words.
module tb_hbm_channel_bridge;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int G    = 4;
  localparam int MAXO = 32;
  localparam int OW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] front_addr;
  logic          front_valid;
  logic          stage_full;
  logic          ctrl_full;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] ctrl_edge;
  logic          ctrl_valid;
  logic [DW-1:0] act_edge;
  logic [G-1:0]  act_valid;
  logic [G-1:0]  act_ready;
  logic [OW-1:0] outstanding;
  logic          err_ovf;
  logic          err_unexp;

  always #5 clk = ~clk;

  hbm_channel_bridge #(
    .HBM_AWIDTH      (AW),
    .HBM_DWIDTH      (DW),
    .GROUP_CORE_NUM  (G),
    .PSEUDO_ID       (0),
    .RQST_DEPTH      (64),
    .RQST_PF_MARGIN  (8),
    .RESP_DEPTH      (64),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .front_rd_hbm_edge_addr  (front_addr),
    .front_rd_hbm_edge_valid (front_valid),
    .stage_full              (stage_full),
    .hbm_controller_full     (ctrl_full),
    .rd_hbm_edge_addr        (rd_addr),
    .rd_hbm_edge_valid       (rd_valid),
    .hbm_controller_edge     (ctrl_edge),
    .hbm_controller_valid    (ctrl_valid),
    .active_v_edge           (act_edge),
    .active_v_edge_valid     (act_valid),
    .active_v_edge_ready     (act_ready),
    .outstanding             (outstanding),
    .err_rqst_overflow       (err_ovf),
    .err_unexpected_resp     (err_unexp)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_issue = 0;
  int mdl_out = 0;
  int cidx [G];
  logic [AW-1:0] rq_q   [$];
  logic [AW-1:0] pend_q [$];
  logic [DW-1:0] resp_q [$];

  typedef struct {
    logic [G-1:0] ready;
    logic [G-1:0] exp_valid;
    int           exp_out;
  } fan_vec_t;

  fan_vec_t fan_tab [5];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    rq_q.delete();
    pend_q.delete();
    resp_q.delete();
    for (int i = 0; i < G; i++) cidx[i] = 0;
    mdl_out = 0;
  endtask

  // One clock; updates the scoreboard from what crossed the edge.
  task automatic step();
    logic          was_rst;
    logic          fprev;
    logic          fv;
    logic [AW-1:0] fa;
    logic          rv;
    logic [DW-1:0] rw;
    logic [DW-1:0] head;
    logic [G-1:0]  acc;
    bit            all_took;
    was_rst = rst;
    fprev   = ctrl_full;
    fv      = front_valid;
    fa      = front_addr;
    rv      = ctrl_valid;
    rw      = ctrl_edge;
    head    = act_edge;
    acc     = act_valid & act_ready;
    @(posedge clk);
    #1;
    if (was_rst) begin
      clear_model();
      return;
    end
    if (rv && mdl_out > 0) resp_q.push_back(rw);
    for (int i = 0; i < G; i++) begin
      if (acc[i]) begin
        chk($sformatf("core%0d_word_avail", i),
            64'(cidx[i] < resp_q.size()), 64'd1);
        if (cidx[i] < resp_q.size())
          chk($sformatf("core%0d_word", i), 64'(head),
              64'(resp_q[cidx[i]]));
        cidx[i]++;
      end
    end
    all_took = 1'b1;
    for (int i = 0; i < G; i++) if (cidx[i] == 0) all_took = 1'b0;
    if (all_took && resp_q.size() > 0) begin
      void'(resp_q.pop_front());
      for (int i = 0; i < G; i++) cidx[i]--;
      mdl_out--;
    end
    if (rd_valid) begin
      n_issue++;
      mdl_out++;
      chk("issue_under_full", 64'(fprev), 64'd0);
      chk("issue_has_rqst", 64'(rq_q.size() > 0), 64'd1);
      if (rq_q.size() > 0)
        chk("issue_addr", 64'(rd_addr), 64'(rq_q.pop_front()));
      pend_q.push_back(rd_addr);
    end
    if (fv) rq_q.push_back(fa);
    chk("outstanding", 64'(outstanding), 64'(mdl_out));
    chk("credit_limit", 64'(outstanding <= OW'(MAXO)), 64'd1);
  endtask

  task automatic drive_resp(input bit en);
    if (en && pend_q.size() > 0) begin
      ctrl_valid = 1'b1;
      ctrl_edge  = word_of(pend_q.pop_front());
    end else begin
      ctrl_valid = 1'b0;
      ctrl_edge  = '0;
    end
  endtask

  task automatic idle_inputs();
    front_valid = 1'b0;
    front_addr  = '0;
    ctrl_full   = 1'b0;
    ctrl_valid  = 1'b0;
    ctrl_edge   = '0;
    act_ready   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_stage_full"}, 64'(stage_full), 64'd0);
    chk({tag, "_edge"}, 64'(act_edge), 64'd0);
    chk({tag, "_valid"}, 64'(act_valid), 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    chk({tag, "_err_ovf"}, 64'(err_ovf), 64'd0);
    chk({tag, "_err_unexp"}, 64'(err_unexp), 64'd0);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    front_valid = 1'b0;
    ctrl_full   = 1'b0;
    act_ready   = '1;
    while (k < 400 && (mdl_out != 0 || rq_q.size() != 0 ||
                       pend_q.size() != 0)) begin
      drive_resp(1'b1);
      step();
      k++;
    end
    ctrl_valid = 1'b0;
    chk({tag, "_drained"}, 64'(mdl_out == 0 && rq_q.size() == 0), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int blocked;
    fan_tab[0] = '{4'b0000, 4'b1111, 1};
    fan_tab[1] = '{4'b0101, 4'b1111, 1};
    fan_tab[2] = '{4'b1010, 4'b1010, 1};
    fan_tab[3] = '{4'b1111, 4'b0000, 0};
    fan_tab[4] = '{4'b0000, 4'b0000, 0};

    rst = 1'b1;
    idle_inputs();
    do_reset();
    chk_zero("reset");

    // Single request latency.
    front_addr  = 32'h100;
    front_valid = 1'b1;
    step();
    front_valid = 1'b0;
    chk("lat_t0", 64'(rd_valid), 64'd0);
    step();
    chk("lat_t1", 64'(rd_valid), 64'd0);
    step();
    chk("lat_t2_valid", 64'(rd_valid), 64'd1);
    chk("lat_t2_addr", 64'(rd_addr), 64'h100);
    chk("lat_t2_out", 64'(outstanding), 64'd1);
    step();
    chk("lat_strobe", 64'(rd_valid), 64'd0);

    // Partial accepts across cores.
    drive_resp(1'b1);
    step();
    ctrl_valid = 1'b0;
    step();
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("fan%0d_valid", r), 64'(act_valid),
          64'(fan_tab[r].exp_valid));
      chk($sformatf("fan%0d_out", r), 64'(outstanding),
          64'(fan_tab[r].exp_out));
      if (fan_tab[r].exp_valid != '0)
        chk($sformatf("fan%0d_word", r), 64'(act_edge),
            64'(word_of(32'h100)));
      act_ready = fan_tab[r].ready;
      step();
    end
    act_ready = '0;

    // Credit limit with no responses.
    do_reset();
    base = n_issue;
    for (int i = 0; i < 40; i++) begin
      front_valid = 1'b1;
      front_addr  = 32'h1000 + i;
      step();
      chk("credit_pf", 64'(stage_full), 64'd0);
    end
    front_valid = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("credit_issues", 64'(n_issue - base), 64'd32);
    chk("credit_out", 64'(outstanding), 64'd32);
    chk("credit_pending", 64'(rq_q.size()), 64'd8);
    drain("credit");

    // Controller backpressure window.
    blocked = 0;
    act_ready = '1;
    for (int i = 0; i < 20; i++) begin
      front_valid = (i < 10);
      front_addr  = 32'h200 + i;
      ctrl_full   = (i >= 3 && i < 8);
      drive_resp(1'b1);
      step();
      if (i >= 3 && i < 8) blocked += int'(rd_valid);
    end
    chk("bp_blocked", 64'(blocked), 64'd0);
    drain("bp");

    // Programmable-full threshold and overflow.
    do_reset();
    ctrl_full = 1'b1;
    for (int i = 0; i < 55; i++) begin
      front_valid = 1'b1;
      front_addr  = 32'h4000 + i;
      step();
    end
    chk("pf_55", 64'(stage_full), 64'd0);
    front_addr = 32'h4037;
    step();
    chk("pf_56", 64'(stage_full), 64'd1);
    for (int i = 0; i < 4; i++) step();
    chk("ovf_60", 64'(err_ovf), 64'd0);
    for (int i = 0; i < 10; i++) step();
    front_valid = 1'b0;
    chk("ovf_70", 64'(err_ovf), 64'd1);
    step();
    chk("ovf_sticky", 64'(err_ovf), 64'd1);
    do_reset();
    chk_zero("ovf_reset");

    // Unexpected response.
    ctrl_valid = 1'b1;
    ctrl_edge  = 32'hDEAD;
    step();
    ctrl_valid = 1'b0;
    chk("unexp_err", 64'(err_unexp), 64'd1);
    step();
    step();
    chk("unexp_dropped", 64'(act_valid), 64'd0);
    chk("unexp_out", 64'(outstanding), 64'd0);

    // Sustained issue and retire, then reset mid-burst.
    do_reset();
    act_ready = '1;
    for (int i = 0; i < 130; i++) begin
      front_valid = 1'b1;
      front_addr  = 32'h3000 + i;
      drive_resp(1'b1);
      step();
      if (i >= 10 && i < 110) chk("steady_out", 64'(outstanding), 64'd3);
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    chk_zero("mid_reset");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_rd", 64'(rd_valid), 64'd0);
      chk("post_rst_valid", 64'(act_valid), 64'd0);
    end

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      front_valid = !stage_full && ($urandom_range(0, 1) == 1);
      front_addr  = $urandom;
      ctrl_full   = ($urandom_range(0, 3) == 0);
      act_ready   = G'($urandom);
      drive_resp($urandom_range(0, 2) != 0);
      step();
    end
    drain("rand");
    chk("rand_err_ovf", 64'(err_ovf), 64'd0);
    chk("rand_err_unexp", 64'(err_unexp), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hbm_channel_bridge.md
Name: hbm_channel_bridge

Overview:
Per-pseudo-channel bridge between the edge-fetch front end and one HBM pseudo-channel controller. It is the parametrised successor of the per-channel request/response path.
- Buffers read requests and issues them to the controller, limiting in-flight reads with a credit counter.
- Buffers returned edge words and fans each one out to GROUP_CORE_NUM cores with per-core valid/ready. A word is retired only after every core has accepted it.
- Flags protocol errors with sticky bits.

Parameters:
- HBM_AWIDTH, `HBM_AWIDTH, request address width.
- HBM_DWIDTH, `HBM_DWIDTH, edge word width.
- GROUP_CORE_NUM, `GROUP_CORE_NUM, cores served by this channel.
- PSEUDO_ID, 0, channel index (debug only).
- RQST_DEPTH, 64, request FIFO depth (power of 2).
- RQST_PF_MARGIN, 8, free slots remaining when stage_full asserts.
- RESP_DEPTH, 64, response FIFO depth (power of 2).
- MAX_OUTSTANDING, 32, in-flight read limit. Must be ≤ RESP_DEPTH; elaboration fails otherwise.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- front_rd_hbm_edge_addr  in  HBM_AWIDTH  request address
- front_rd_hbm_edge_valid  in  1  request write strobe
- stage_full  out  1  registered; request FIFO occupancy ≥ RQST_DEPTH-RQST_PF_MARGIN
- hbm_controller_full  in  1  controller cannot accept a request this cycle
- rd_hbm_edge_addr  out  HBM_AWIDTH  issued address
- rd_hbm_edge_valid  out  1  issue strobe, one cycle per request
- hbm_controller_edge  in  HBM_DWIDTH  returned edge word
- hbm_controller_valid  in  1  response strobe
- active_v_edge  out  HBM_DWIDTH  head response word, shared by all cores
- active_v_edge_valid  out  GROUP_CORE_NUM  per-core valid
- active_v_edge_ready  in  GROUP_CORE_NUM  per-core ready
- outstanding  out  log2(MAX_OUTSTANDING)+1  current in-flight count
- err_rqst_overflow  out  1  sticky: write while request FIFO full (request dropped)
- err_unexpected_resp  out  1  sticky: response while outstanding==0 (word dropped)

Behaviour:
- Reset: clk edge with rst=1 clears both FIFOs, outstanding, delivered mask and error bits. All outputs read 0 in the following cycle. Reset mid-operation discards all buffered and in-flight state.
- Request FIFO: show-ahead. A write on front_rd_hbm_edge_valid is visible at the head after the next edge.
- Issue condition: head valid & !hbm_controller_full & outstanding < MAX_OUTSTANDING. On issue:
  - pop the head;
  - register addr/valid, so rd_hbm_edge_valid is high in the next cycle;
  - increment outstanding.
- Issue latency: when idle, front write at edge t gives rd_hbm_edge_valid high in the cycle after edge t+2. Sustained throughput is 1 request/clk.
- Backpressure: hbm_controller_full is sampled in the same cycle as the issue decision. No request is issued while it is high.
- Response FIFO: written on hbm_controller_valid with no ready path. The credit limit guarantees space because outstanding counts issued-not-retired words.
- Unexpected response: if outstanding==0 when a response arrives, the word is dropped and err_unexpected_resp is set.
- Fan-out: register delivered[GROUP_CORE_NUM].
  - active_v_edge_valid[i] = head valid & !delivered[i].
  - Core i accepts when valid[i] & ready[i], which sets delivered[i].
  - When (delivered | accept) is all ones, pop the head, clear delivered and decrement outstanding.
  - All cores accepting in the same cycle retires the word in 1 clk. Sustained throughput is 1 word/clk.
- Simultaneous issue and retire in one cycle leave outstanding unchanged.
- outstanding never exceeds MAX_OUTSTANDING and never underflows.
- Overflow: a write to a full request FIFO is dropped and sets err_rqst_overflow. Empty FIFO pops are blocked by the issue condition.
- Pointers are log2(DEPTH)+1 bits with wrap bit; full = MSBs differ and other bits equal.

Decomposition:
- accelerator.vh gains defaults for `HBM_RQST_DEPTH, `HBM_RESP_DEPTH and `HBM_MAX_OUTSTANDING.
- One natural sub-module: sync_fifo_fwft (params WIDTH, DEPTH, PF_MARGIN; ports clk, rst, wr_en, din, rd_en, dout, empty, full, prog_full). It is instantiated twice and replaces the vendor FIFO IP.

Test Plan:
- Single request 0x100 with controller idle -> rd_hbm_edge_valid high exactly 2 clks after the write edge, addr 0x100; outstanding=1.
- 40 back-to-back requests, MAX_OUTSTANDING=32, no responses -> exactly 32 issues, then stall. stage_full stays 0 until occupancy reaches 56.
- hbm_controller_full high for 5 clks during a burst -> zero issues in those cycles; order preserved after release.
- GROUP_CORE_NUM=4 with ready=4'b0101, then 4'b1010 -> word retired on the second accept cycle. Valid drops per core after its accept; outstanding decrements once.
- Simultaneous issue and retire for 100 cycles -> outstanding constant; data order matches request order.
- Response with outstanding==0, and rst asserted mid-burst -> err_unexpected_resp=1 and word dropped. After reset, all outputs and outstanding are 0 and the FIFOs are empty.
